mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single unified instruction/data RAM between two requesters: the core's memory port (fetch and load/store, driven from the Adr/MemWrite path) and the program loader/debug port. Serves one transaction at a time through a small FSM. Uses round-robin fairness and returns a one-cycle done pulse per transaction. Sits between the core datapath and the RAM instance, with the loader as a second master.

Parameters:
ADDR_W, 10, word-address width; matches the 1024-deep RAM.
DATA_W, 32, data width.
RD_LAT, 1, RAM read latency in cycles from address presented to mem_rdata valid; legal range 1..7.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
core_req  in  1  core requests access; held until core_gnt
core_we  in  1  1 = write, 0 = read; sampled with req
core_addr  in  ADDR_W  word address
core_wdata  in  DATA_W  write data
core_gnt  out  1  one-cycle pulse: core request accepted, inputs latched
core_done  out  1  one-cycle pulse: core transaction complete
core_rdata  out  DATA_W  read data; valid when core_done on a read, held until the next core read completes
ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader equivalents of the core inputs
ldr_gnt, ldr_done, ldr_rdata  out  1/1/DATA_W  loader equivalents of the core outputs
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset values: state = IDLE; last_owner = LDR, so the core wins the first tie. All gnt/done = 0; mem_we = 0; latched addr/wdata/we = 0; core_rdata = ldr_rdata = 0; busy = 0.
- IDLE:
  - Only one request high: grant it.
  - Both high: grant the port that is not last_owner.
  - Grant cycle: pulse that port's gnt; latch owner, we, addr, wdata; update last_owner; next state = ISSUE.
  - No request: stay in IDLE.
- ISSUE (1 cycle):
  - mem_addr = latched addr; mem_wdata = latched wdata; mem_we = latched we.
  - Write: pulse owner's done in this cycle; next state = IDLE.
  - Read: load wait counter with RD_LAT; next state = WAIT.
- WAIT:
  - Counter decrements each cycle; mem_we = 0; mem_addr stays at the latched addr.
  - When counter == 1: capture mem_rdata into owner's rdata register, pulse owner's done, next state = IDLE.
- Latency from gnt cycle T: write done at T+1; read done at T+1+RD_LAT (T+2 at default).
- Throughput: IDLE is mandatory between transactions. A request that is high in a done cycle is granted in the following IDLE cycle.
- Requester rules: req must stay high until gnt; may drop or change the cycle after gnt. Inputs are not re-sampled mid-transaction.
- Outside ISSUE/WAIT, mem_addr/mem_wdata hold the last latched values; mem_we = 0.
- mem_we is combinational from state and latched we, gated by ~reset. No RAM write occurs in a reset cycle, even if reset arrives in ISSUE.
- Reset mid-transaction: abort; no done pulse for the aborted transaction; rdata registers cleared.
- gnt and done never assert for both ports in the same cycle. At most one gnt and one done per transaction.
- Width rules: the wait counter is 3 bits. RD_LAT outside 1..7 is a static elaboration error via an assertion.

Decomposition:
- Shared package amp_mem_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_ISSUE, ARB_WAIT};
  - port-index constants PORT_CORE = 1'b0, PORT_LDR = 1'b1;
  - default ADDR_W/DATA_W localparams reused by the RAM and core.
- One natural sub-module, rr_pick2: combinational 2-way round-robin pick from {req0, req1, last_owner} giving {valid, winner}. Reusable for a later register-file write-port arbiter.

Test Plan:
1. Reset, then core_req = 1, core_we = 0, core_addr = 10'h004, RAM[4] = 32'hDEADBEEF -> core_gnt at T; mem_addr = 4 at T+1; core_done and core_rdata = 32'hDEADBEEF at T+2; ldr_* outputs stay 0.
2. ldr write addr 10'h010, data 32'h00000013 -> ldr_gnt at T; mem_we = 1 only at T+1; ldr_done at T+1; a later core read of 10'h010 returns 32'h00000013.
3. core_req and ldr_req both held high for 6 transactions -> grants alternate core, ldr, core, ldr, ... with the core first after reset; never two gnts in one cycle.
4. RD_LAT = 3 build, core read -> core_done at T+4; busy high from T+1 through T+4; mem_we stays 0.
5. Reset asserted in the ISSUE cycle of an ldr write to 10'h020 (old value 32'h0) -> mem_we = 0 that cycle; RAM[0x20] still 0; no ldr_done; all outputs at reset values next cycle.
6. core_req raised in the same cycle as the ldr_done of an ldr write -> core_gnt in the following cycle (IDLE), not the done cycle; core transaction completes normally.

Source files
------------

// File: rtl/amp_mem_pkg.sv
// Shared definitions for the unified instruction/data memory subsystem.
// Used by the memory arbiter today and intended for reuse by the RAM wrapper
// and the core datapath.
//   arb_state_t : arbiter FSM state encoding
//   PORT_CORE / PORT_LDR : requester indices used as owner / round-robin history
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths (1024 x 32 RAM)
package amp_mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LDR  = 1'b1;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick.
// Ports:
//   req0, req1  : request lines (index 0 / index 1)
//   last_owner  : index that won the previous arbitration
//   valid       : at least one request is present
//   winner      : index of the chosen requester (meaningful only when valid)
// On a tie the requester that did not win last time is chosen.
module rr_pick2
    import amp_mem_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic valid,
    output logic winner
);

    assign valid  = req0 | req1;
    assign winner = (req0 & req1) ? ~last_owner
                                  : (req1 ? PORT_LDR : PORT_CORE);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one unified instruction/data RAM between the core memory
// port and the program loader/debug port. One transaction is in flight at a
// time; ties are broken round-robin.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   core_req/we/addr/wdata          : core request (held until core_gnt)
//   core_gnt, core_done, core_rdata : core grant pulse, completion pulse, read data
//   ldr_*                           : loader equivalents of the core_* ports
//   mem_we/addr/wdata, mem_rdata    : RAM interface (read data RD_LAT cycles after addr)
//   busy                            : high whenever a transaction is in progress
//
// Handshake: a requester raises req with we/addr/wdata valid and holds them
// until it sees gnt. gnt is a one-cycle pulse in the IDLE cycle that accepts
// the request (inputs are latched at the end of that cycle); the requester may
// change or drop req the cycle after gnt. done is a one-cycle pulse ending the
// transaction; on a read, rdata is valid during done and holds afterwards.
module mem_arbiter
    import amp_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_done,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // The wait counter is 3 bits wide, so only latencies 1..7 are representable.
    generate
        if ((RD_LAT < 1) || (RD_LAT > 7)) begin : g_bad_rd_lat
            $error("mem_arbiter: RD_LAT must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    arb_state_t        state;
    logic              owner;
    logic              last_owner;
    logic              we_l;
    logic [ADDR_W-1:0] addr_l;
    logic [DATA_W-1:0] wdata_l;
    logic [2:0]        cnt;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] ldr_rdata_q;

    logic pick_valid;
    logic pick_winner;
    logic grant;
    logic wr_done;
    logic rd_done;
    logic xfer_done;

    rr_pick2 u_pick (
        .req0       (core_req),
        .req1       (ldr_req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    // gnt and done are decoded from the registered state in the same cycle
    // they refer to: gnt must appear in the accepting IDLE cycle and a write
    // must complete in its ISSUE cycle. Every term is gated by reset so an
    // aborted transaction never signals anything.
    assign grant     = ~reset & (state == ARB_IDLE) & pick_valid;
    assign wr_done   = ~reset & (state == ARB_ISSUE) & we_l;
    assign rd_done   = ~reset & (state == ARB_WAIT) & (cnt == 3'd1);
    assign xfer_done = wr_done | rd_done;

    assign core_gnt  = grant & (pick_winner == PORT_CORE);
    assign ldr_gnt   = grant & (pick_winner == PORT_LDR);
    assign core_done = xfer_done & (owner == PORT_CORE);
    assign ldr_done  = xfer_done & (owner == PORT_LDR);

    // RAM data is only valid in the final WAIT cycle, so it is forwarded
    // during done and held in the register from then on.
    assign core_rdata = (rd_done && owner == PORT_CORE) ? mem_rdata : core_rdata_q;
    assign ldr_rdata  = (rd_done && owner == PORT_LDR)  ? mem_rdata : ldr_rdata_q;

    // The write strobe equals the write-completion condition.
    assign mem_we    = wr_done;
    assign mem_addr  = addr_l;
    assign mem_wdata = wdata_l;
    assign busy      = (state != ARB_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            last_owner   <= PORT_LDR;
            owner        <= PORT_CORE;
            we_l         <= 1'b0;
            addr_l       <= '0;
            wdata_l      <= '0;
            cnt          <= '0;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner      <= pick_winner;
                        last_owner <= pick_winner;
                        if (pick_winner == PORT_LDR) begin
                            we_l    <= ldr_we;
                            addr_l  <= ldr_addr;
                            wdata_l <= ldr_wdata;
                        end else begin
                            we_l    <= core_we;
                            addr_l  <= core_addr;
                            wdata_l <= core_wdata;
                        end
                        state <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (we_l) begin
                        state <= ARB_IDLE;
                    end else begin
                        cnt   <= LAT_LOAD;
                        state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (cnt == 3'd1) begin
                        if (owner == PORT_LDR) begin
                            ldr_rdata_q <= mem_rdata;
                        end else begin
                            core_rdata_q <= mem_rdata;
                        end
                        state <= ARB_IDLE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a default-latency instance plus an
// RD_LAT = 3 instance sharing the same requester inputs, each with its own
// RAM model.
module tb_mem_arbiter;

    localparam int MAIN_LAT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        core_req = 1'b0;
    logic        core_we = 1'b0;
    logic [9:0]  core_addr = '0;
    logic [31:0] core_wdata = '0;
    logic        ldr_req = 1'b0;
    logic        ldr_we = 1'b0;
    logic [9:0]  ldr_addr = '0;
    logic [31:0] ldr_wdata = '0;

    logic        core_gnt, core_done, ldr_gnt, ldr_done, mem_we, busy;
    logic [31:0] core_rdata, ldr_rdata, mem_wdata;
    logic [9:0]  mem_addr;
    logic [31:0] mem_rdata = '0;

    logic        core_gnt3, core_done3, ldr_gnt3, ldr_done3, mem_we3, busy3;
    logic [31:0] core_rdata3, ldr_rdata3, mem_wdata3;
    logic [9:0]  mem_addr3;
    logic [31:0] mem_rdata3 = '0;
    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;

    logic        pre_we = 1'b0;
    logic [9:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    logic [31:0] ram  [0:1023] = '{default: 32'h0};
    logic [31:0] ram3 [0:1023] = '{default: 32'h0};
    logic [31:0] ref_mem [0:1023];

    // {port, we, expected rdata}
    logic [33:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_arbiter u_dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_done(core_done), .core_rdata(core_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt), .ldr_done(ldr_done), .ldr_rdata(ldr_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    mem_arbiter #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt3), .core_done(core_done3), .core_rdata(core_rdata3),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_gnt(ldr_gnt3), .ldr_done(ldr_done3), .ldr_rdata(ldr_rdata3),
        .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
        .busy(busy3)
    );

    // RAM models: 1-cycle read for the main instance, 3-stage read pipe for u_dut3.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr]  <= pre_data;
            ram3[pre_addr] <= pre_data;
        end else begin
            if (mem_we)  ram[mem_addr]   <= mem_wdata;
            if (mem_we3) ram3[mem_addr3] <= mem_wdata3;
        end
        mem_rdata  <= ram[mem_addr];
        p1         <= ram3[mem_addr3];
        p2         <= p1;
        mem_rdata3 <= p2;
    end

    // Scoreboard for the main instance: every done pops one expectation.
    always @(negedge clk) begin
        logic [33:0] e;
        logic [31:0] rd;
        if (!reset) begin
            if (core_gnt || ldr_gnt) begin
                n_vec++;
                if (core_gnt && ldr_gnt) begin
                    n_err++;
                    $display("FAIL dual_gnt: core_gnt=%b ldr_gnt=%b, required at most one", core_gnt, ldr_gnt);
                end
            end
            if (core_done || ldr_done) begin
                n_vec++;
                if (core_done && ldr_done) begin
                    n_err++;
                    $display("FAIL dual_done: both done pulses high at cycle %0d", cyc);
                end else if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: core_done=%b ldr_done=%b with empty queue", core_done, ldr_done);
                end else begin
                    e = exp_q.pop_front();
                    rd = e[33] ? ldr_rdata : core_rdata;
                    if (ldr_done !== e[33]) begin
                        n_err++;
                        $display("FAIL done_port: got ldr_done=%b required %b", ldr_done, e[33]);
                    end else if (!e[32] && rd !== e[31:0]) begin
                        n_err++;
                        $display("FAIL rdata: got %h required %h", rd, e[31:0]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        core_req = 1'b0;
        ldr_req = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        tick();
        pre_we = 1'b1;
        pre_addr = a;
        pre_data = d;
        ref_mem[a] = d;
        tick();
        pre_we = 1'b0;
    endtask

    // Single transaction on the main instance with grant and latency checks.
    task automatic txn(input logic port, input logic we, input logic [9:0] a, input logic [31:0] d);
        int  tg;
        logic got;
        tick();
        if (port) begin
            ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
        end else begin
            core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
        end
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (port ? ldr_gnt : core_gnt) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL gnt_timeout: port %0d got no gnt, required within 20 cycles", port);
            core_req = 1'b0;
            ldr_req = 1'b0;
            return;
        end
        tg = cyc;
        exp_q.push_back({port, we, we ? 32'h0 : ref_mem[a]});
        if (we) ref_mem[a] = d;
        tick();
        core_req = 1'b0;
        ldr_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (port ? ldr_done : core_done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL done_timeout: port %0d got no done, required within 20 cycles", port);
        end else if (cyc - tg != (we ? 1 : 1 + MAIN_LAT)) begin
            n_err++;
            $display("FAIL latency: got %0d cycles required %0d", cyc - tg, we ? 1 : 1 + MAIN_LAT);
        end
    endtask

    task automatic test_reset();
        core_req = 1'b1;
        tick();
        @(negedge clk);
        n_vec++;
        if ({core_gnt, ldr_gnt, core_done, ldr_done, mem_we, busy, busy3} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required 0000000",
                     {core_gnt, ldr_gnt, core_done, ldr_done, mem_we, busy, busy3});
        end
        n_vec++;
        if ({core_rdata, ldr_rdata} !== 64'h0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h required 0", {core_rdata, ldr_rdata});
        end
        n_vec++;
        if ({mem_addr, mem_wdata} !== 42'h0) begin
            n_err++;
            $display("FAIL reset_mem_bus: got %h required 0", {mem_addr, mem_wdata});
        end
        tick();
        core_req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, mem_we, core_gnt} !== 3'b0) begin
            n_err++;
            $display("FAIL post_reset_idle: got %b required 000", {busy, mem_we, core_gnt});
        end
    endtask

    task automatic test_core_read();
        preload(10'h004, 32'hDEADBEEF);
        tick();
        core_req = 1'b1; core_we = 1'b0; core_addr = 10'h004;
        @(negedge clk);
        n_vec++;
        if (core_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rd_gnt: got %b required 1", core_gnt);
        end else begin
            exp_q.push_back({1'b0, 1'b0, ref_mem[10'h004]});
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            core_req = 1'b0;
            @(negedge clk);
            n_vec++;
            if (core_done !== (k == 2)) begin
                n_err++;
                $display("FAIL rd_done_T%0d: got %b required %b", k, core_done, k == 2);
            end
            n_vec++;
            if ({ldr_gnt, ldr_done, ldr_rdata} !== 34'h0) begin
                n_err++;
                $display("FAIL ldr_quiet_T%0d: got %h required 0", k, {ldr_gnt, ldr_done, ldr_rdata});
            end
            if (k == 1) begin
                n_vec++;
                if ({mem_addr, mem_we, busy} !== {10'h004, 1'b0, 1'b1}) begin
                    n_err++;
                    $display("FAIL rd_issue: got addr=%h we=%b busy=%b required 004 0 1", mem_addr, mem_we, busy);
                end
            end
            if (k == 3) begin
                n_vec++;
                if (core_rdata !== 32'hDEADBEEF) begin
                    n_err++;
                    $display("FAIL rd_hold: got %h required deadbeef", core_rdata);
                end
            end
        end
    endtask

    task automatic test_ldr_write();
        tick();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 10'h010; ldr_wdata = 32'h00000013;
        @(negedge clk);
        n_vec++;
        if ({ldr_gnt, mem_we} !== 2'b10) begin
            n_err++;
            $display("FAIL wr_gnt: got gnt,we=%b required 10", {ldr_gnt, mem_we});
        end else begin
            exp_q.push_back({1'b1, 1'b1, 32'h0});
            ref_mem[10'h010] = 32'h00000013;
        end
        tick();
        ldr_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({mem_we, ldr_done, mem_addr, mem_wdata} !== {1'b1, 1'b1, 10'h010, 32'h00000013}) begin
            n_err++;
            $display("FAIL wr_issue: got we=%b done=%b addr=%h data=%h required 1 1 010 00000013",
                     mem_we, ldr_done, mem_addr, mem_wdata);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if ({mem_we, busy, ldr_done} !== 3'b0) begin
            n_err++;
            $display("FAIL wr_after: got we,busy,done=%b required 000", {mem_we, busy, ldr_done});
        end
        txn(1'b0, 1'b0, 10'h010, 32'h0);
    endtask

    task automatic test_round_robin();
        int ng;
        do_reset();
        tick();
        core_req = 1'b1; core_we = 1'b0; core_addr = 10'h004;
        ldr_req = 1'b1;  ldr_we = 1'b0;  ldr_addr = 10'h010;
        ng = 0;
        for (int k = 0; k < 60 && ng < 6; k++) begin
            @(negedge clk);
            if (core_gnt || ldr_gnt) begin
                n_vec++;
                if ({core_gnt, ldr_gnt} !== ((ng % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_err++;
                    $display("FAIL rr_order_%0d: got core,ldr=%b required %b", ng,
                             {core_gnt, ldr_gnt}, (ng % 2 == 0) ? 2'b10 : 2'b01);
                end
                exp_q.push_back({ldr_gnt, 1'b0, ldr_gnt ? ref_mem[10'h010] : ref_mem[10'h004]});
                ng++;
            end
            tick();
        end
        core_req = 1'b0;
        ldr_req = 1'b0;
        n_vec++;
        if (ng != 6) begin
            n_err++;
            $display("FAIL rr_count: got %0d grants required 6", ng);
        end
        repeat (4) tick();
    endtask

    task automatic test_rd_lat3();
        do_reset();
        tick();
        core_req = 1'b1; core_we = 1'b0; core_addr = 10'h004;
        @(negedge clk);
        n_vec++;
        if ({core_gnt3, ldr_gnt3, ldr_done3, ldr_rdata3} !== {3'b100, 32'h0}) begin
            n_err++;
            $display("FAIL lat3_gnt: got %h required %h", {core_gnt3, ldr_gnt3, ldr_done3, ldr_rdata3}, {3'b100, 32'h0});
        end
        if (core_gnt) exp_q.push_back({1'b0, 1'b0, ref_mem[10'h004]});
        for (int k = 1; k <= 5; k++) begin
            tick();
            core_req = 1'b0;
            @(negedge clk);
            n_vec++;
            if ({busy3, mem_we3, core_done3} !== {(k <= 4), 1'b0, (k == 4)}) begin
                n_err++;
                $display("FAIL lat3_T%0d: got busy,we,done=%b required %b", k,
                         {busy3, mem_we3, core_done3}, {(k <= 4), 1'b0, (k == 4)});
            end
            if (k == 4) begin
                n_vec++;
                if (core_rdata3 !== ref_mem[10'h004]) begin
                    n_err++;
                    $display("FAIL lat3_rdata: got %h required %h", core_rdata3, ref_mem[10'h004]);
                end
            end
        end
    endtask

    task automatic test_reset_in_issue();
        tick();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 10'h020; ldr_wdata = 32'hCAFEF00D;
        @(negedge clk);
        n_vec++;
        if (ldr_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL abort_gnt: got %b required 1", ldr_gnt);
        end
        tick();
        ldr_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({mem_we, ldr_done} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_issue: got we,done=%b required 00", {mem_we, ldr_done});
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({core_gnt, ldr_gnt, core_done, ldr_done, mem_we, busy} !== 6'b0) begin
            n_err++;
            $display("FAIL abort_ctrl: got %b required 000000",
                     {core_gnt, ldr_gnt, core_done, ldr_done, mem_we, busy});
        end
        n_vec++;
        if ({core_rdata, ldr_rdata, mem_addr, mem_wdata} !== 106'h0) begin
            n_err++;
            $display("FAIL abort_data: got %h required 0", {core_rdata, ldr_rdata, mem_addr, mem_wdata});
        end
        n_vec++;
        if (ram[10'h020] !== 32'h0) begin
            n_err++;
            $display("FAIL abort_ram: got %h required 00000000", ram[10'h020]);
        end
        txn(1'b0, 1'b0, 10'h020, 32'h0);
    endtask

    task automatic test_req_in_done();
        tick();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 10'h030; ldr_wdata = 32'h00000055;
        @(negedge clk);
        n_vec++;
        if (ldr_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rid_ldr_gnt: got %b required 1", ldr_gnt);
        end else begin
            exp_q.push_back({1'b1, 1'b1, 32'h0});
            ref_mem[10'h030] = 32'h00000055;
        end
        tick();
        ldr_req = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 10'h030;
        @(negedge clk);
        n_vec++;
        if ({ldr_done, core_gnt} !== 2'b10) begin
            n_err++;
            $display("FAIL rid_done_cycle: got done,gnt=%b required 10", {ldr_done, core_gnt});
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (core_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL rid_core_gnt: got %b required 1", core_gnt);
        end else begin
            exp_q.push_back({1'b0, 1'b0, ref_mem[10'h030]});
        end
        tick();
        core_req = 1'b0;
        @(negedge clk);
        n_vec++;
        if (core_done !== 1'b0) begin
            n_err++;
            $display("FAIL rid_early_done: got %b required 0", core_done);
        end
        tick();
        @(negedge clk);
        n_vec++;
        if (core_done !== 1'b1) begin
            n_err++;
            $display("FAIL rid_core_done: got %b required 1", core_done);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        test_reset();
        test_core_read();
        test_ldr_write();
        test_round_robin();
        test_rd_lat3();
        test_reset_in_issue();
        test_req_in_done();
        repeat (4) tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d pending transactions required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
